mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 135 +++++++++++++
 tb/tb_mem_wb_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage data-memory handshake plus the MEM/WB pipeline register.
// Result visible one edge after the completing cycle; upstream is held via stall_o until ack or timeout.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MEM_RegWrite_i,
    input  logic        MEM_MemtoReg_i,
    input  logic        MEM_MemRead_i,
    input  logic        MEM_MemWrite_i,
    input  logic [31:0] MEM_ALUOut_i,
    input  logic [31:0] MEM_RS2data_i,
    input  logic [4:0]  MEM_RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        WB_RegWrite_o,
    output logic [4:0]  WB_RDaddr_o,
    output logic [31:0] WB_WriteData_o,
    output logic        mem_err_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_rw_q, wb_rw_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        err_q, err_d;

    logic        access;
    logic        aligned;
    logic        req;
    logic        misalign;
    logic        timeout_now;
    logic        req_out;
    logic        stall;
    logic        bubble;

    assign access  = MEM_MemRead_i | MEM_MemWrite_i;
    assign aligned = (MEM_ALUOut_i[1:0] == 2'b00);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req         = 1'b0;
        misalign    = 1'b0;
        timeout_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (access && aligned) begin
                    req = 1'b1;
                    if (!mem_ack_i) begin
                        state_d = ST_WAIT;
                    end
                end else if (access) begin
                    misalign = 1'b1;
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_now = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gating with reset drops the request immediately even while access inputs are still present.
    assign req_out = req & rst_i;
    assign stall   = req_out & ~mem_ack_i & ~timeout_now;
    assign bubble  = stall | timeout_now | misalign;

    always_comb begin
        wb_rw_d  = 1'b0;
        wb_rd_d  = '0;
        wb_dat_d = '0;
        if (!bubble) begin
            wb_rw_d  = MEM_RegWrite_i & ~MEM_MemWrite_i;
            wb_rd_d  = MEM_RDaddr_i;
            wb_dat_d = MEM_MemtoReg_i ? mem_rdata_i : MEM_ALUOut_i;
        end
    end

    assign err_d = err_q | timeout_now | misalign;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wb_rw_q  <= 1'b0;
            wb_rd_q  <= '0;
            wb_dat_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wb_rw_q  <= wb_rw_d;
            wb_rd_q  <= wb_rd_d;
            wb_dat_q <= wb_dat_d;
            err_q    <= err_d;
        end
    end

    assign mem_req_o      = req_out;
    assign mem_we_o       = req_out & MEM_MemWrite_i;
    assign mem_addr_o     = req_out ? MEM_ALUOut_i : 32'h0;
    assign mem_wdata_o    = req_out ? MEM_RS2data_i : 32'h0;
    assign stall_o        = stall;
    assign WB_RegWrite_o  = wb_rw_q;
    assign WB_RDaddr_o    = wb_rd_q;
    assign WB_WriteData_o = wb_dat_q;
    assign mem_err_o      = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: constant vector table, hand-written multi-cycle sequences,
// and a randomized instruction stream checked against a per-instruction outcome model.
module tb_mem_wb_stage;
    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MEM_RegWrite_i, MEM_MemtoReg_i, MEM_MemRead_i, MEM_MemWrite_i;
    logic [31:0] MEM_ALUOut_i, MEM_RS2data_i;
    logic [4:0]  MEM_RDaddr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, WB_RegWrite_o, mem_err_o;
    logic [4:0]  WB_RDaddr_o;
    logic [31:0] WB_WriteData_o;

    int   n_pass = 0;
    int   n_total = 0;
    logic err_m = 1'b0;

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_MemtoReg_i(MEM_MemtoReg_i),
        .MEM_MemRead_i(MEM_MemRead_i), .MEM_MemWrite_i(MEM_MemWrite_i),
        .MEM_ALUOut_i(MEM_ALUOut_i), .MEM_RS2data_i(MEM_RS2data_i), .MEM_RDaddr_i(MEM_RDaddr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .WB_RegWrite_o(WB_RegWrite_o), .WB_RDaddr_o(WB_RDaddr_o),
        .WB_WriteData_o(WB_WriteData_o), .mem_err_o(mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rw, m2r, rd_en, wr_en;
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_we, e_stall, e_wrw;
        logic [4:0]  e_wrd;
        logic [31:0] e_wdat;
        logic        e_err;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic rd_en, input logic wr_en,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
        MEM_RegWrite_i = rw;
        MEM_MemtoReg_i = m2r;
        MEM_MemRead_i  = rd_en;
        MEM_MemWrite_i = wr_en;
        MEM_ALUOut_i   = alu;
        MEM_RS2data_i  = rs2;
        MEM_RDaddr_i   = rd;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk1({tag, "_wb_rw"}, WB_RegWrite_o, 1'b0);
        chk({tag, "_wb_rd"}, 32'(WB_RDaddr_o), 32'h0);
        chk({tag, "_wb_data"}, WB_WriteData_o, 32'h0);
    endtask

    // One instruction held at the stage inputs until it leaves. k is the request cycle
    // (0 = first) on which memory acks; k > TO means memory never answers.
    task automatic run_instr(input logic rw, input logic m2r, input logic rd_en, input logic wr_en,
                             input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                             input int k, input logic [31:0] rdat_fin,
                             output int n_stall, output int n_req);
        logic        acc, mis, ereq, ok;
        int          last;
        logic [31:0] rdat;
        acc  = rd_en | wr_en;
        mis  = acc && (alu[1:0] != 2'b00);
        ereq = acc && !mis;
        if (!ereq)       last = 0;
        else if (k <= TO) last = k;
        else             last = TO;
        ok = !mis && !(ereq && k > TO);
        n_stall = 0;
        n_req   = 0;
        drive(rw, m2r, rd_en, wr_en, alu, rs2, rd);
        for (int c = 0; c <= last; c++) begin
            rdat        = (c == last) ? rdat_fin : $urandom;
            mem_rdata_i = rdat;
            mem_ack_i   = ereq ? (c == k) : 1'($urandom_range(0, 1));
            @(negedge clk_i);
            chk1("req", mem_req_o, ereq);
            chk1("stall", stall_o, ereq && (c != last));
            chk1("we", mem_we_o, ereq && wr_en);
            chk("addr", mem_addr_o, ereq ? alu : 32'h0);
            chk("wdata", mem_wdata_o, ereq ? rs2 : 32'h0);
            n_req   += int'(mem_req_o);
            n_stall += int'(stall_o);
            @(posedge clk_i); #1;
            if (c == last && ok) begin
                chk1("wb_rw", WB_RegWrite_o, rw && !wr_en);
                chk("wb_rd", 32'(WB_RDaddr_o), 32'(rd));
                chk("wb_data", WB_WriteData_o, m2r ? rdat : alu);
            end else begin
                chk_wb_zero("bubble");
            end
        end
        if (!ok) err_m = 1'b1;
        chk1("err", mem_err_o, err_m);
    endtask

    task automatic pulse_reset();
        rst_i = 1'b0;
        #2;
        chk1("rstp_req", mem_req_o, 1'b0);
        chk1("rstp_stall", stall_o, 1'b0);
        chk1("rstp_err", mem_err_o, 1'b0);
        chk_wb_zero("rstp");
        rst_i = 1'b1;
        err_m = 1'b0;
    endtask

    initial begin
        int          ns, nr, kind, k;
        logic        rw, m2r, rd_en, wr_en;
        logic [31:0] alu, rs2;
        logic [4:0]  rd;

        //            rw m2r rd wr alu           rs2           rd ack rdata          req we st wrw wrd wdat           err
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 5'd7, 1'b1, 32'h0BAD_0BAD,
                   1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0000_0040, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd9, 1'b1, 32'h1122_3344,
                   1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1122_3344, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0, 5'd0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hABCD_0000, 32'h0, 5'd3, 1'b1, 32'h0000_0077,
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'hABCD_0000, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0005, 5'd12, 1'b1, 32'h0000_0099,
                   1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0099, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd4, 1'b0, 32'h0000_0055,
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1};

        // Reset with an aligned load already present: request must stay low.
        rst_i = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        #3;
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_err", mem_err_o, 1'b0);
        chk_wb_zero("rst");
        repeat (2) @(posedge clk_i);
        #1;
        chk_wb_zero("rst_clk");
        chk1("rst_clk_req", mem_req_o, 1'b0);
        rst_i = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].rw, tbl[i].m2r, tbl[i].rd_en, tbl[i].wr_en, tbl[i].alu, tbl[i].rs2, tbl[i].rd);
            mem_ack_i   = tbl[i].ack;
            mem_rdata_i = tbl[i].rdata;
            @(negedge clk_i);
            chk1($sformatf("tbl%0d_req", i), mem_req_o, tbl[i].e_req);
            chk1($sformatf("tbl%0d_we", i), mem_we_o, tbl[i].e_we);
            chk1($sformatf("tbl%0d_stall", i), stall_o, tbl[i].e_stall);
            chk($sformatf("tbl%0d_addr", i), mem_addr_o, tbl[i].e_req ? tbl[i].alu : 32'h0);
            chk($sformatf("tbl%0d_wdata", i), mem_wdata_o, tbl[i].e_req ? tbl[i].rs2 : 32'h0);
            @(posedge clk_i); #1;
            chk1($sformatf("tbl%0d_wb_rw", i), WB_RegWrite_o, tbl[i].e_wrw);
            chk($sformatf("tbl%0d_wb_rd", i), 32'(WB_RDaddr_o), 32'(tbl[i].e_wrd));
            chk($sformatf("tbl%0d_wb_data", i), WB_WriteData_o, tbl[i].e_wdat);
            chk1($sformatf("tbl%0d_err", i), mem_err_o, tbl[i].e_err);
            err_m = tbl[i].e_err;
        end

        // Load acked on the third request cycle.
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd6, 2, 32'hDEAD_BEEF, ns, nr);
        chk("load3_stall_cycles", 32'(ns), 32'd2);
        chk("load3_data", WB_WriteData_o, 32'hDEAD_BEEF);

        // Reset pulse during the second WAIT cycle.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd8);
        mem_ack_i = 1'b0;
        repeat (2) begin
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        chk1("wait2_req", mem_req_o, 1'b1);
        chk1("wait2_stall", stall_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk1("wait_rst_req", mem_req_o, 1'b0);
        chk1("wait_rst_stall", stall_o, 1'b0);
        chk1("wait_rst_err", mem_err_o, 1'b0);
        chk_wb_zero("wait_rst");
        @(posedge clk_i); #1;
        chk1("wait_rst_clk_req", mem_req_o, 1'b0);
        chk_wb_zero("wait_rst_clk");
        rst_i = 1'b1;
        err_m = 1'b0;
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd8, 1, 32'hCAFE_F00D, ns, nr);
        chk("fresh_load_stall_cycles", 32'(ns), 32'd1);
        chk("fresh_load_data", WB_WriteData_o, 32'hCAFE_F00D);
        chk1("fresh_load_err", mem_err_o, 1'b0);

        // Timeout: IDLE cycle plus TO WAIT cycles of request, the final one unstalled.
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd10, TO + 1, 32'h0, ns, nr);
        chk("timeout_req_cycles", 32'(nr), 32'd5);
        chk("timeout_stall_cycles", 32'(ns), 32'd4);
        chk1("timeout_err", mem_err_o, 1'b1);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h42, 32'h0, 5'd11, 0, 32'h0, ns, nr);
        chk("after_timeout_data", WB_WriteData_o, 32'h42);
        chk1("after_timeout_err_sticky", mem_err_o, 1'b1);

        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 59) pulse_reset();
            kind  = int'($urandom_range(0, 8));
            rw    = 1'($urandom);
            m2r   = 1'($urandom);
            alu   = $urandom;
            rs2   = $urandom;
            rd    = 5'($urandom);
            rd_en = 1'b0;
            wr_en = 1'b0;
            if (kind >= 3 && kind <= 5) begin
                rd_en = 1'b1;
                alu[1:0] = 2'b00;
            end else if (kind == 6 || kind == 7) begin
                wr_en = 1'b1;
                rd_en = 1'($urandom);
                alu[1:0] = 2'b00;
            end else if (kind == 8) begin
                rd_en = 1'($urandom);
                wr_en = !rd_en;
                alu[1:0] = 2'($urandom_range(1, 3));
            end
            k = int'($urandom_range(0, TO + 1));
            run_instr(rw, m2r, rd_en, wr_en, alu, rs2, rd, k, $urandom, ns, nr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
